cla_seq_adder: RTL

//  Parametrised multi-cycle carry-lookahead adder/subtractor built on 4-bit lookahead groups.

---
 rtl/cla_seq_adder_pkg.sv | 14 +
 rtl/cla_group4.sv | 41 ++++
 rtl/cla_seq_adder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
//   state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   GRP_W   : width of one lookahead group in bits
package cla_seq_adder_pkg;

    localparam int GRP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
//   a, b : group operand bits (b already inverted for subtraction)
//   c    : carry into the group
//   s    : group sum bits
//   Pg   : group propagate (AND of bit propagates)
//   Gg   : group generate
//   cout : carry out of the group
module cla_group4
    import cla_seq_adder_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             c,
    output logic [GRP_W-1:0] s,
    output logic             Pg,
    output logic             Gg,
    output logic             cout
);

    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] ci;

    // p uses OR rather than XOR: it still yields correct lookahead carries
    // and matches the definition of the word-level P flag.
    assign p = a | b;
    assign g = a & b;

    assign ci[0] = c;
    assign ci[1] = g[0] | (p[0] & c);
    assign ci[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign ci[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c);

    assign s    = a ^ b ^ ci;
    assign Pg   = &p;
    assign Gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cout = Gg | (Pg & c);

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor.
// Processes GPC 4-bit groups per cycle, LSB first, with the inter-beat
// carry held in a register. Results are registered and qualified by
// out_valid.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub        : operands; sub=1 computes a-b (cin ignored)
//   out_valid / out_ready : result handshake (result held until accepted)
//   sum, cout, ovfl, zero : result and flags
//   P, G                  : whole-word propagate / generate
//   dbg_state             : current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised by this block, stays high with stable data
// until the transfer; ready never depends combinationally on valid.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             P,
    output logic             G,
    output logic [1:0]       dbg_state
);

    localparam int BW     = GRP_W * GPC;
    localparam int NBEATS = WIDTH / BW;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if ((GPC < 1) || ((WIDTH % BW) != 0)) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 4*GPC");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               p_acc_q, p_acc_d;
    logic               g_acc_q, g_acc_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;
    logic               zero_q, zero_d;
    logic               p_q, p_d;
    logic               g_q, g_d;

    // Slice of the operands handled this beat.
    logic [BW-1:0]      a_beat;
    logic [BW-1:0]      b_beat;
    logic [BW-1:0]      s_beat;
    logic [GPC:0]       c_chain;
    logic [GPC-1:0]     pg_vec;
    logic [GPC-1:0]     gg_vec;

    assign a_beat     = a_q[int'(beat_q) * BW +: BW];
    assign b_beat     = b_q[int'(beat_q) * BW +: BW];
    assign c_chain[0] = carry_q;

    for (genvar j = 0; j < GPC; j++) begin : g_grp
        cla_group4 u_grp (
            .a    (a_beat[j*GRP_W +: GRP_W]),
            .b    (b_beat[j*GRP_W +: GRP_W]),
            .c    (c_chain[j]),
            .s    (s_beat[j*GRP_W +: GRP_W]),
            .Pg   (pg_vec[j]),
            .Gg   (gg_vec[j]),
            .cout (c_chain[j+1])
        );
    end

    logic             p_beat;
    logic             g_beat;
    logic [WIDTH-1:0] full_sum;
    logic             last_beat;

    always_comb begin
        // Fold this beat's groups into the running word P/G, higher group
        // taking priority over the accumulated lower part.
        p_beat = p_acc_q;
        g_beat = g_acc_q;
        for (int j = 0; j < GPC; j++) begin
            g_beat = gg_vec[j] | (pg_vec[j] & g_beat);
            p_beat = p_beat & pg_vec[j];
        end

        full_sum = acc_q;
        full_sum[int'(beat_q) * BW +: BW] = s_beat;

        last_beat = (beat_q == BEAT_W'(NBEATS - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        p_acc_d = p_acc_q;
        g_acc_d = g_acc_q;
        beat_d  = beat_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        p_d     = p_q;
        g_d     = g_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    acc_d   = '0;
                    beat_d  = '0;
                    p_acc_d = 1'b1;
                    g_acc_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = full_sum;
                carry_d = c_chain[GPC];
                p_acc_d = p_beat;
                g_acc_d = g_beat;
                beat_d  = beat_q + 1'b1;
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                    sum_d   = full_sum;
                    cout_d  = c_chain[GPC];
                    // Carry into the MSB recovered from the MSB sum bit.
                    ovfl_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full_sum[WIDTH-1])
                            ^ c_chain[GPC];
                    zero_d  = (full_sum == '0);
                    p_d     = p_beat;
                    g_d     = g_beat;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            p_acc_q <= 1'b0;
            g_acc_q <= 1'b0;
            beat_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            p_acc_q <= p_acc_d;
            g_acc_q <= g_acc_d;
            beat_q  <= beat_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            p_q     <= p_d;
            g_q     <= g_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovfl      = ovfl_q;
    assign zero      = zero_q;
    assign P         = p_q;
    assign G         = g_q;
    assign dbg_state = state_q;

endmodule
